// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider request scheduler.
package div_sched_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [DATA_WIDTH_DEFAULT-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_req_fifo.sv
// Request queue for div_scheduler; pointers carry one extra wrap bit to tell full from empty.
module div_req_fifo
  import div_sched_pkg::*;
#(
  parameter int WIDTH = 2 * DATA_WIDTH_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/div_scheduler.sv
// Queues divide requests and feeds them one at a time to an external divider.
// Build option DIV_SCHED_DBZ_BYPASS_EN answers zero-divisor requests locally with rsp_dbz set.
//
// state    | meaning
// ST_IDLE  | waiting for a queued request; pops head into operand registers
// ST_ISSUE | div_start high for one cycle
// ST_WAIT  | operands held, waiting for div_done
// ST_RESP  | response held until rsp_ready
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_dividend,
  input  logic [DATA_WIDTH-1:0] req_divisor,
  output logic                  div_start,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  input  logic                  div_done,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic [DATA_WIDTH-1:0] div_remainder,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_quotient,
  output logic [DATA_WIDTH-1:0] rsp_remainder,
  output logic                  rsp_dbz,
  output logic                  busy
);

`ifdef DIV_SCHED_DBZ_BYPASS_EN
  localparam bit DBZ_BYPASS = 1'b1;
`else
  localparam bit DBZ_BYPASS = 1'b0;
`endif

  // Replicated so the all-ones pattern holds for any DATA_WIDTH.
  localparam logic [DATA_WIDTH-1:0] DBZ_Q = {DATA_WIDTH{DBZ_QUOTIENT[0]}};

  state_t                  r_state;
  logic                    r_div_start;
  logic [DATA_WIDTH-1:0]   r_dividend;
  logic [DATA_WIDTH-1:0]   r_divisor;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_quotient;
  logic [DATA_WIDTH-1:0]   r_rsp_remainder;
  logic                    r_rsp_dbz;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [2*DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0]   w_head_dividend;
  logic [DATA_WIDTH-1:0]   w_head_divisor;

  assign req_ready       = !w_full;
  assign w_push          = req_valid && req_ready;
  assign w_pop           = (r_state == ST_IDLE) && !w_empty;
  assign w_head_dividend = w_head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_head_divisor  = w_head[DATA_WIDTH-1:0];

  div_req_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({req_dividend, req_divisor}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_div_start     <= 1'b0;
      r_dividend      <= '0;
      r_divisor       <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_quotient  <= '0;
      r_rsp_remainder <= '0;
      r_rsp_dbz       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_dividend <= w_head_dividend;
            r_divisor  <= w_head_divisor;
            if (DBZ_BYPASS && (w_head_divisor == '0)) begin
              r_state         <= ST_RESP;
              r_rsp_valid     <= 1'b1;
              r_rsp_quotient  <= DBZ_Q;
              r_rsp_remainder <= w_head_dividend;
              r_rsp_dbz       <= 1'b1;
            end else begin
              r_state     <= ST_ISSUE;
              r_div_start <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          r_div_start <= 1'b0;
          r_state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (div_done) begin
            r_rsp_quotient  <= div_quotient;
            r_rsp_remainder <= div_remainder;
            r_rsp_valid     <= 1'b1;
            r_rsp_dbz       <= 1'b0;
            r_state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_dbz   <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign div_start     = r_div_start;
  assign div_dividend  = r_dividend;
  assign div_divisor   = r_divisor;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_quotient  = r_rsp_quotient;
  assign rsp_remainder = r_rsp_remainder;
  assign rsp_dbz       = r_rsp_dbz;
  assign busy          = (r_state != ST_IDLE) || !w_empty;

endmodule
